// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and the sample-point indices within one bit period.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    localparam logic [3:0] TICK_SAMPLE0 = 4'd7;
    localparam logic [3:0] TICK_SAMPLE1 = 4'd8;
    localparam logic [3:0] TICK_DECIDE  = 4'd9;
    localparam logic [3:0] TICK_END     = 4'd15;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Programmable oversample tick generator: one-cycle tick every baud_div+1
// clocks, re-phased to zero by a synchronous restart.
module uart_baud_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 restart,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt_reg;

    // >= rather than == so a divisor lowered on the fly still wraps.
    assign tick = !restart && (cnt_reg >= baud_div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (restart || (cnt_reg >= baud_div)) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// 16x oversampling UART receiver with majority-vote sampling, parity/framing
// checks and a single-entry valid/ready output register.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 rx_sync,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);

    if (OVERSAMPLE != uart_pkg::OVERSAMPLE) begin : g_bad_oversample
        $error("uart_rx_core: OVERSAMPLE must be 16");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_core: DATA_BITS must be 5..9");
    end

    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    rx_state_t            state_reg;
    logic [3:0]           tick_idx_reg;
    logic [3:0]           bit_cnt_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 s0_reg;
    logic                 s1_reg;
    logic                 parity_bad_reg;

    logic tick;
    logic restart;
    logic vote;
    logic out_free;

    assign restart  = (state_reg == IDLE) && !rx_sync;
    assign vote     = majority3(s0_reg, s1_reg, rx_sync);
    assign out_free = !rx_valid || rx_ready;
    assign busy     = (state_reg != IDLE);

    uart_baud_gen #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_baud_gen (
        .clk     (clk),
        .rst     (rst),
        .baud_div(baud_div),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= WAIT_IDLE;
            tick_idx_reg   <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            s0_reg         <= 1'b0;
            s1_reg         <= 1'b0;
            parity_bad_reg <= 1'b0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            frame_err      <= 1'b0;
            parity_err     <= 1'b0;
            overrun_err    <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (tick) begin
                tick_idx_reg <= tick_idx_reg + 1'b1;
                if (tick_idx_reg == TICK_SAMPLE0) s0_reg <= rx_sync;
                if (tick_idx_reg == TICK_SAMPLE1) s1_reg <= rx_sync;
            end

            case (state_reg)
                WAIT_IDLE: begin
                    if (rx_sync) state_reg <= IDLE;
                end

                IDLE: begin
                    if (!rx_sync) begin
                        state_reg      <= START;
                        tick_idx_reg   <= '0;
                        bit_cnt_reg    <= '0;
                        parity_bad_reg <= 1'b0;
                    end
                end

                START: begin
                    if (tick) begin
                        if (tick_idx_reg == TICK_DECIDE && vote) begin
                            state_reg <= IDLE;
                        end else if (tick_idx_reg == TICK_END) begin
                            state_reg <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (tick_idx_reg == TICK_DECIDE) begin
                            shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
                        end
                        if (tick_idx_reg == TICK_END) begin
                            if (bit_cnt_reg == LAST_BIT) begin
                                state_reg <= parity_en ? PARITY : STOP;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            end
                        end
                    end
                end

                PARITY: begin
                    if (tick) begin
                        if (tick_idx_reg == TICK_DECIDE) begin
                            parity_bad_reg <= ((^shift_reg) ^ vote) != parity_odd;
                        end
                        if (tick_idx_reg == TICK_END) begin
                            state_reg <= STOP;
                        end
                    end
                end

                STOP: begin
                    // Completing at the mid-bit decision leaves slack for baud mismatch.
                    if (tick && tick_idx_reg == TICK_DECIDE) begin
                        state_reg <= vote ? IDLE : WAIT_IDLE;
                        if (out_free) begin
                            rx_data    <= shift_reg;
                            frame_err  <= !vote;
                            parity_err <= parity_bad_reg;
                            rx_valid   <= 1'b1;
                        end else begin
                            overrun_err <= 1'b1;
                        end
                    end
                end

                default: state_reg <= WAIT_IDLE;
            endcase
        end
    end

endmodule
